// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single data-cache port shared by the load buffer and committed stores
// Stores win ties until a waiting load has been passed over STARVE_LIMIT times in a row.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic        ld_resp,
  output logic [31:0] ld_rdata,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [3:0]  st_byte_en,
  output logic        st_resp,
  output logic        mem_read_d,
  output logic        mem_write_d,
  output logic [31:0] mem_address_d,
  output logic [31:0] mem_wdata_d,
  output logic [3:0]  mem_byte_enable_d,
  input  logic        mem_resp_d,
  input  logic [31:0] mem_rdata_d,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, LOAD, STORE, LOAD_SQUASH} state_t;
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t      r_state, w_state_next;
  logic [2:0]  r_starve_cnt, w_starve_next;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_byte_en;
  logic        w_ld_eff, w_grant_st, w_grant_ld;

  // A flushed load request is not eligible for a grant in the same cycle.
  assign w_ld_eff = ld_req & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_starve_cnt <= 3'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_byte_en    <= 4'd0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_next;
      if (w_grant_st) begin
        r_addr    <= st_addr;
        r_wdata   <= st_wdata;
        r_byte_en <= st_byte_en;
      end else if (w_grant_ld) begin
        r_addr    <= ld_addr;
        r_wdata   <= 32'd0;
        r_byte_en <= 4'b1111;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_grant_st    = 1'b0;
    w_grant_ld    = 1'b0;
    w_starve_next = r_starve_cnt;
    case (r_state)
      IDLE: begin
        if (st_req && !(w_ld_eff && r_starve_cnt == LIMIT)) begin
          w_grant_st   = 1'b1;
          w_state_next = STORE;
          if (!ld_req)
            w_starve_next = 3'd0;
          else if (r_starve_cnt != LIMIT)
            w_starve_next = r_starve_cnt + 3'd1;
        end else if (w_ld_eff) begin
          w_grant_ld    = 1'b1;
          w_state_next  = LOAD;
          w_starve_next = 3'd0;
        end
      end
      LOAD: begin
        if (mem_resp_d)
          w_state_next = IDLE;
        else if (flush)
          w_state_next = LOAD_SQUASH;
      end
      STORE, LOAD_SQUASH: begin
        if (mem_resp_d)
          w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (flush)
      w_starve_next = 3'd0;
  end

  assign busy              = (r_state != IDLE);
  assign mem_read_d        = (r_state == LOAD) || (r_state == LOAD_SQUASH);
  assign mem_write_d       = (r_state == STORE);
  assign mem_address_d     = r_addr;
  assign mem_wdata_d       = r_wdata;
  assign mem_byte_enable_d = r_byte_en;
  assign ld_resp           = (r_state == LOAD) & mem_resp_d & ~flush;
  assign ld_rdata          = ld_resp ? mem_rdata_d : 32'd0;
  assign st_resp           = (r_state == STORE) & mem_resp_d;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed scenarios plus randomized traffic against a transaction-level model
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_dmem_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ld_req = 1'b0;
  logic [31:0] ld_addr = 32'd0;
  logic        ld_resp;
  logic [31:0] ld_rdata;
  logic        st_req = 1'b0;
  logic [31:0] st_addr = 32'd0;
  logic [31:0] st_wdata = 32'd0;
  logic [3:0]  st_byte_en = 4'd0;
  logic        st_resp;
  logic        mem_read_d, mem_write_d;
  logic [31:0] mem_address_d, mem_wdata_d;
  logic [3:0]  mem_byte_enable_d;
  logic        mem_resp_d = 1'b0;
  logic [31:0] mem_rdata_d = 32'd0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Model: which transaction is in flight (0 none, 1 load, 2 store, 3 load killed by flush)
  int          m_kind;
  int          m_streak;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_resp(ld_resp), .ld_rdata(ld_rdata),
    .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata), .st_byte_en(st_byte_en),
    .st_resp(st_resp),
    .mem_read_d(mem_read_d), .mem_write_d(mem_write_d), .mem_address_d(mem_address_d),
    .mem_wdata_d(mem_wdata_d), .mem_byte_enable_d(mem_byte_enable_d),
    .mem_resp_d(mem_resp_d), .mem_rdata_d(mem_rdata_d), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_req = 1'b1; st_req = 1'b1; mem_resp_d = 1'b1; mem_rdata_d = 32'hA5A5A5A5;
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({ld_resp, st_resp, mem_read_d, mem_write_d, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {ld_resp, st_resp, mem_read_d, mem_write_d, busy});
    end
    checks++;
    if (mem_address_d !== 32'd0 || mem_wdata_d !== 32'd0 || mem_byte_enable_d !== 4'd0 || ld_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h be=%h rdata=%h expected all zero",
               mem_address_d, mem_wdata_d, mem_byte_enable_d, ld_rdata);
    end
    ld_req = 1'b0; st_req = 1'b0; mem_resp_d = 1'b0; rst = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_lone_load();
    int pulses = 0;
    logic [31:0] got_data = 32'd0;
    ld_req = 1'b1; ld_addr = 32'h100;
    tick();
    @(negedge clk);
    if (ld_resp) pulses++;
    checks++;
    if (mem_read_d !== 1'b1 || mem_write_d !== 1'b0 || mem_address_d !== 32'h100) begin
      errors++;
      $display("FAIL lone_issue: rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=00000100", mem_read_d, mem_write_d, mem_address_d);
    end
    checks++;
    if (mem_byte_enable_d !== 4'hF || mem_wdata_d !== 32'd0) begin
      errors++;
      $display("FAIL lone_be_wdata: be=%h wdata=%h expected be=f wdata=0", mem_byte_enable_d, mem_wdata_d);
    end
    for (int i = 1; i <= 2; i++) begin
      tick();
      if (i == 2) begin mem_resp_d = 1'b1; mem_rdata_d = 32'hDEADBEEF; end
      @(negedge clk);
      if (ld_resp) begin pulses++; got_data = ld_rdata; end
      checks++;
      if (mem_read_d !== 1'b1 || mem_address_d !== 32'h100) begin
        errors++;
        $display("FAIL lone_hold: rd=%b addr=%h expected rd=1 addr=00000100", mem_read_d, mem_address_d);
      end
    end
    tick();
    mem_resp_d = 1'b0; ld_req = 1'b0;
    @(negedge clk);
    if (ld_resp) pulses++;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL lone_busy_drop: busy=%b expected 0", busy); end
    checks++;
    if (pulses != 1 || got_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lone_resp: pulses=%0d data=%h expected pulses=1 data=deadbeef", pulses, got_data);
    end
  endtask

  task automatic test_simultaneous();
    ld_req = 1'b1; ld_addr = 32'h200;
    st_req = 1'b1; st_addr = 32'h300; st_wdata = 32'h12345678; st_byte_en = 4'b0011;
    tick();
    mem_resp_d = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_write_d !== 1'b1 || mem_read_d !== 1'b0 || mem_address_d !== 32'h300 ||
        mem_wdata_d !== 32'h12345678 || mem_byte_enable_d !== 4'b0011) begin
      errors++;
      $display("FAIL simul_store_first: wr=%b rd=%b addr=%h wdata=%h be=%b expected wr=1 rd=0 addr=00000300 wdata=12345678 be=0011",
               mem_write_d, mem_read_d, mem_address_d, mem_wdata_d, mem_byte_enable_d);
    end
    checks++;
    if (st_resp !== 1'b1 || ld_resp !== 1'b0) begin
      errors++;
      $display("FAIL simul_st_resp: st_resp=%b ld_resp=%b expected 1 0", st_resp, ld_resp);
    end
    tick();
    st_req = 1'b0; mem_resp_d = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_read_d !== 1'b0 || mem_write_d !== 1'b0) begin
      errors++;
      $display("FAIL simul_bubble: busy=%b rd=%b wr=%b expected 0 0 0", busy, mem_read_d, mem_write_d);
    end
    tick();
    mem_resp_d = 1'b1; mem_rdata_d = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    if (mem_read_d !== 1'b1 || mem_address_d !== 32'h200 || mem_byte_enable_d !== 4'hF ||
        mem_wdata_d !== 32'd0 || ld_resp !== 1'b1 || ld_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL simul_load_second: rd=%b addr=%h be=%h wdata=%h ld_resp=%b rdata=%h expected 1 00000200 f 0 1 cafef00d",
               mem_read_d, mem_address_d, mem_byte_enable_d, mem_wdata_d, ld_resp, ld_rdata);
    end
    tick();
    ld_req = 1'b0; mem_resp_d = 1'b0;
  endtask

  task automatic test_starvation();
    string got = "";
    int guard = 0;
    ld_req = 1'b1; ld_addr = 32'h240;
    st_req = 1'b1; st_addr = 32'h340; st_wdata = 32'h55AA55AA; st_byte_en = 4'hF;
    mem_resp_d = 1'b1;
    while (got.len() < 6 && guard < 40) begin
      tick();
      guard++;
      @(negedge clk);
      if (mem_write_d) got = {got, "S"};
      else if (mem_read_d) got = {got, "L"};
      if (ld_resp) ld_req = 1'b0;
    end
    st_req = 1'b0; ld_req = 1'b0;
    tick();
    mem_resp_d = 1'b0;
    checks++;
    if (got != "SSSSLS") begin
      errors++;
      $display("FAIL starve_sequence: got %s expected SSSSLS (cycles=%0d)", got, guard);
    end
  endtask

  task automatic test_flush_load();
    int pulses = 0;
    ld_req = 1'b1; ld_addr = 32'h400;
    tick();
    flush = 1'b1; ld_req = 1'b0;
    @(negedge clk);
    if (ld_resp) pulses++;
    for (int c = 2; c <= 4; c++) begin
      tick();
      flush = 1'b0;
      mem_resp_d = (c == 4);
      @(negedge clk);
      if (ld_resp) pulses++;
      checks++;
      if (mem_read_d !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL flush_read_held: cycle=%0d rd=%b busy=%b expected 1 1", c, mem_read_d, busy);
      end
    end
    tick();
    mem_resp_d = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pulses != 0) begin
      errors++;
      $display("FAIL flush_no_resp: busy=%b pulses=%0d expected busy=0 pulses=0", busy, pulses);
    end
    ld_req = 1'b1; ld_addr = 32'h500;
    tick();
    mem_resp_d = 1'b1; mem_rdata_d = 32'h0BADF00D;
    @(negedge clk);
    checks++;
    if (mem_address_d !== 32'h500 || ld_resp !== 1'b1 || ld_rdata !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL flush_next_grant: addr=%h ld_resp=%b rdata=%h expected 00000500 1 0badf00d", mem_address_d, ld_resp, ld_rdata);
    end
    tick();
    ld_req = 1'b0; mem_resp_d = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h600;
    tick();
    flush = 1'b1; mem_resp_d = 1'b1; ld_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ld_resp !== 1'b0) begin errors++; $display("FAIL flush_with_resp: ld_resp=%b expected 0", ld_resp); end
    tick();
    flush = 1'b0; mem_resp_d = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_with_resp_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_flush_store();
    int pulses = 0;
    st_req = 1'b1; st_addr = 32'h700; st_wdata = 32'h11223344; st_byte_en = 4'b1100; flush = 1'b1;
    tick();
    @(negedge clk);
    if (st_resp) pulses++;
    checks++;
    if (mem_write_d !== 1'b1 || mem_address_d !== 32'h700 || mem_byte_enable_d !== 4'b1100) begin
      errors++;
      $display("FAIL flush_store_grant: wr=%b addr=%h be=%b expected 1 00000700 1100", mem_write_d, mem_address_d, mem_byte_enable_d);
    end
    tick();
    flush = 1'b0; mem_resp_d = 1'b1;
    @(negedge clk);
    if (st_resp) pulses++;
    checks++;
    if (mem_write_d !== 1'b1) begin errors++; $display("FAIL flush_store_held: wr=%b expected 1", mem_write_d); end
    tick();
    st_req = 1'b0; mem_resp_d = 1'b0;
    @(negedge clk);
    if (st_resp) pulses++;
    checks++;
    if (pulses != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_store_resp: pulses=%0d busy=%b expected pulses=1 busy=0", pulses, busy);
    end
  endtask

  task automatic test_async_reset();
    ld_req = 1'b1; ld_addr = 32'h800;
    tick();
    @(negedge clk);
    mem_resp_d = 1'b1; mem_rdata_d = 32'h77778888;
    #1;
    checks++;
    if (mem_read_d !== 1'b1 || ld_resp !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: rd=%b ld_resp=%b expected 1 1", mem_read_d, ld_resp);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (mem_read_d !== 1'b0 || ld_resp !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate: rd=%b ld_resp=%b busy=%b expected 0 0 0", mem_read_d, ld_resp, busy);
    end
    @(negedge clk);
    rst = 1'b0; ld_req = 1'b0; mem_resp_d = 1'b0;
    st_req = 1'b1; st_addr = 32'h900; st_wdata = 32'h9ABCDEF0; st_byte_en = 4'hF;
    tick();
    @(negedge clk);
    checks++;
    if (mem_write_d !== 1'b1 || mem_address_d !== 32'h900 || mem_wdata_d !== 32'h9ABCDEF0) begin
      errors++;
      $display("FAIL areset_new_store: wr=%b addr=%h wdata=%h expected 1 00000900 9abcdef0", mem_write_d, mem_address_d, mem_wdata_d);
    end
    mem_resp_d = 1'b1;
    #1;
    checks++;
    if (st_resp !== 1'b1) begin errors++; $display("FAIL areset_store_resp: st_resp=%b expected 1", st_resp); end
    tick();
    st_req = 1'b0; mem_resp_d = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL areset_store_done: busy=%b expected 0", busy); end
  endtask

  // Advance the model by one clock edge using the inputs the DUT is sampling.
  task automatic model_step();
    logic load_eligible;
    load_eligible = ld_req && !flush;
    if (m_kind == 0) begin
      if (st_req && !(load_eligible && m_streak == LIMIT)) begin
        m_kind = 2; m_addr = st_addr; m_wdata = st_wdata; m_be = st_byte_en;
        m_streak = ld_req ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
      end else if (load_eligible) begin
        m_kind = 1; m_addr = ld_addr; m_wdata = 32'd0; m_be = 4'hF; m_streak = 0;
      end
    end else if (m_kind == 1) begin
      if (mem_resp_d) m_kind = 0;
      else if (flush) m_kind = 3;
    end else if (mem_resp_d) begin
      m_kind = 0;
    end
    if (flush) m_streak = 0;
  endtask

  task automatic test_random();
    logic ld_done = 1'b0;
    logic st_done = 1'b0;
    logic [4:0] exp_ctrl;
    rst = 1'b1; flush = 1'b0; ld_req = 1'b0; st_req = 1'b0; mem_resp_d = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b0;
    m_kind = 0; m_streak = 0; m_addr = 32'd0; m_wdata = 32'd0; m_be = 4'd0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      model_step();
      #1;
      if (ld_done) ld_req = 1'b0;
      else if (!ld_req && $urandom_range(2) == 0) begin ld_req = 1'b1; ld_addr = $urandom; end
      if (st_done) st_req = 1'b0;
      else if (!st_req && $urandom_range(2) == 0) begin
        st_req = 1'b1; st_addr = $urandom; st_wdata = $urandom; st_byte_en = 4'($urandom_range(15));
      end
      flush = ($urandom_range(9) == 0);
      mem_resp_d = ($urandom_range(2) == 0);
      mem_rdata_d = $urandom;
      exp_ctrl = {m_kind != 0, m_kind == 1 || m_kind == 3, m_kind == 2,
                  m_kind == 1 && mem_resp_d && !flush, m_kind == 2 && mem_resp_d};
      @(negedge clk);
      checks++;
      if ({busy, mem_read_d, mem_write_d, ld_resp, st_resp} !== exp_ctrl) begin
        errors++;
        $display("FAIL rand_ctrl: cycle=%0d busy/rd/wr/ldr/str got %b expected %b", n,
                 {busy, mem_read_d, mem_write_d, ld_resp, st_resp}, exp_ctrl);
      end
      checks++;
      if (mem_address_d !== m_addr || mem_wdata_d !== m_wdata || mem_byte_enable_d !== m_be) begin
        errors++;
        $display("FAIL rand_data: cycle=%0d got addr=%h wdata=%h be=%h expected addr=%h wdata=%h be=%h", n,
                 mem_address_d, mem_wdata_d, mem_byte_enable_d, m_addr, m_wdata, m_be);
      end
      if (exp_ctrl[1]) begin
        checks++;
        if (ld_rdata !== mem_rdata_d) begin
          errors++;
          $display("FAIL rand_rdata: cycle=%0d got %h expected %h", n, ld_rdata, mem_rdata_d);
        end
      end
      ld_done = ld_resp;
      st_done = st_resp;
    end
    flush = 1'b0; ld_req = 1'b0; st_req = 1'b0; mem_resp_d = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lone_load();
    test_simultaneous();
    test_starvation();
    test_flush_load();
    test_flush_store();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
